// File: rtl/sram_dump_unit.sv
// Post-halt SRAM readback: walks an address range through the shared read port,
// streams each word on a valid/ready interface and keeps a modular checksum.
module sram_dump_unit #(
  parameter int unsigned word_size = 8,
  parameter int unsigned addr_size = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [addr_size-1:0] first_addr,
  input  logic [addr_size-1:0] last_addr,
  output logic [addr_size-1:0] mem_addr,
  output logic                 mem_rd,
  input  logic [word_size-1:0] mem_data,
  output logic [word_size-1:0] dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 busy,
  output logic                 done,
  output logic [word_size-1:0] checksum
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPT,
    S_SEND,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [addr_size-1:0] end_q, end_d;
  logic [addr_size-1:0] addr_d;
  logic                 rd_d;
  logic [word_size-1:0] dout_d;
  logic                 valid_d;
  logic                 busy_d;
  logic                 done_d;
  logic [word_size-1:0] sum_d;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Output and datapath registers; mem_addr doubles as the walking address counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr   <= '0;
      end_q      <= '0;
      mem_rd     <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      checksum   <= '0;
    end else begin
      mem_addr   <= addr_d;
      end_q      <= end_d;
      mem_rd     <= rd_d;
      dout       <= dout_d;
      dout_valid <= valid_d;
      busy       <= busy_d;
      done       <= done_d;
      checksum   <= sum_d;
    end
  end

  // Next-state and next-output logic; mem_rd is set on entry to READ so it is high only there
  always_comb begin
    state_d = state_q;
    addr_d  = mem_addr;
    end_d   = end_q;
    rd_d    = 1'b0;
    dout_d  = dout;
    valid_d = dout_valid;
    busy_d  = busy;
    done_d  = done;
    sum_d   = checksum;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          addr_d  = first_addr;
          end_d   = last_addr;
          sum_d   = '0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          rd_d    = 1'b1;
          state_d = S_READ;
        end
      end

      S_READ: begin
        state_d = S_CAPT;
      end

      S_CAPT: begin
        dout_d  = mem_data;
        valid_d = 1'b1;
        state_d = S_SEND;
      end

      S_SEND: begin
        if (dout_ready) begin
          sum_d   = checksum + dout;
          valid_d = 1'b0;
          if (mem_addr == end_q) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            addr_d  = mem_addr + addr_size'(1);
            rd_d    = 1'b1;
            state_d = S_READ;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sram_dump_unit.sv
// Bench for sram_dump_unit: SRAM model, handshake monitor and a range-based reference model.
module tb_sram_dump_unit;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] first_addr;
  logic [7:0] last_addr;
  logic [7:0] mem_addr;
  logic       mem_rd;
  logic [7:0] mem_data;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       busy;
  logic       done;
  logic [7:0] checksum;

  sram_dump_unit #(.word_size(8), .addr_size(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
    .done       (done),
    .checksum   (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read SRAM: data appears the cycle after the read strobe
  logic [7:0] mem [256];
  initial mem_data = 8'h00;
  always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

  // Monitor: every read strobe and every accepted word, observed mid-cycle
  logic [7:0] got_words[$];
  logic [7:0] got_addrs[$];
  int         rd_cnt = 0;
  always @(negedge clk) begin
    if (rst === 1'b1 && mem_rd === 1'b1) begin
      got_addrs.push_back(mem_addr);
      rd_cnt++;
    end
    if (rst === 1'b1 && dout_valid === 1'b1 && dout_ready === 1'b1)
      got_words.push_back(dout);
  end

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_words[$];
  logic [7:0] exp_addrs[$];
  logic [7:0] exp_sum;
  logic [7:0] dw[$];
  logic [7:0] da[$];
  int         dump_rd;
  int         stall_seen;
  int         stall_bad;
  bit         timed_out;

  // Reference: word list and checksum straight from the range rules
  function automatic void build_model(input logic [7:0] f, input logic [7:0] l);
    int n;
    int total;
    int a;
    exp_words.delete();
    exp_addrs.delete();
    n = ((int'(l) - int'(f) + 256) % 256) + 1;
    total = 0;
    for (int i = 0; i < n; i++) begin
      a = (int'(f) + i) % 256;
      exp_addrs.push_back(8'(a));
      exp_words.push_back(mem[a]);
      total += int'(mem[a]);
    end
    exp_sum = 8'(total % 256);
  endfunction

  // Drive one dump to completion; optional stall, random ready, or extra start pulses
  task automatic run_dump(input logic [7:0] f, input logic [7:0] l, input int stall_word,
                          input int stall_len, input bit rand_ready, input int mid_start);
    int  bw, ba, rd0, hs;
    bit  finished, pulsed, stalling;
    bw = got_words.size();
    ba = got_addrs.size();
    rd0 = rd_cnt;
    build_model(f, l);
    @(posedge clk); #1;
    first_addr = f; last_addr = l; start = 1'b1; dout_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    first_addr = 8'($urandom); last_addr = 8'($urandom);
    stall_seen = 0; stall_bad = 0; finished = 1'b0; pulsed = 1'b0;
    for (int c = 0; c < 5000 && !finished; c++) begin
      hs = got_words.size() - bw;
      stalling = 1'b0;
      if (stall_len > 0 && hs == stall_word && dout_valid === 1'b1 && stall_seen < stall_len) begin
        dout_ready = 1'b0;
        stall_seen++;
        stalling = 1'b1;
      end else begin
        dout_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      start = 1'b0;
      if (!pulsed && mid_start == 1 && hs == 1) begin
        start = 1'b1; pulsed = 1'b1;
      end else if (!pulsed && mid_start == 2 && hs == exp_words.size() - 1 &&
                   dout_valid === 1'b1 && dout_ready === 1'b1) begin
        start = 1'b1; pulsed = 1'b1;
      end
      @(negedge clk);
      if (stalling && (dout_valid !== 1'b1 || dout !== exp_words[stall_word] || mem_rd !== 1'b0))
        stall_bad++;
      if (done === 1'b1 && busy === 1'b0) finished = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
    dout_ready = 1'b1;
    timed_out = !finished;
    dw.delete();
    da.delete();
    for (int i = bw; i < got_words.size(); i++) dw.push_back(got_words[i]);
    for (int i = ba; i < got_addrs.size(); i++) da.push_back(got_addrs[i]);
    dump_rd = rd_cnt - rd0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; first_addr = 8'h00; last_addr = 8'h00; dout_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    n_checks++; if (mem_addr !== 8'h00) $display("FAIL reset_mem_addr got=%0d exp=0", mem_addr); else n_pass++;
    n_checks++; if (mem_rd !== 1'b0) $display("FAIL reset_mem_rd got=%b exp=0", mem_rd); else n_pass++;
    n_checks++; if (dout !== 8'h00) $display("FAIL reset_dout got=%0d exp=0", dout); else n_pass++;
    n_checks++; if (dout_valid !== 1'b0) $display("FAIL reset_dout_valid got=%b exp=0", dout_valid); else n_pass++;
    n_checks++; if ({busy, done} !== 2'b00) $display("FAIL reset_busy_done got=%b exp=00", {busy, done}); else n_pass++;
    n_checks++; if (checksum !== 8'h00) $display("FAIL reset_checksum got=%0d exp=0", checksum); else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
  endtask

  // First read one cycle after start, first valid three cycles after start
  task automatic test_latency();
    int waited;
    @(posedge clk); #1;
    first_addr = 8'd128; last_addr = 8'd128; start = 1'b1; dout_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    n_checks++; if ({mem_rd, busy, mem_addr} !== {1'b1, 1'b1, 8'd128})
      $display("FAIL lat_read got rd=%b busy=%b addr=%0d exp 1 1 128", mem_rd, busy, mem_addr); else n_pass++;
    @(negedge clk);
    n_checks++; if ({mem_rd, dout_valid} !== 2'b00)
      $display("FAIL lat_capt got rd=%b valid=%b exp 0 0", mem_rd, dout_valid); else n_pass++;
    @(negedge clk);
    n_checks++; if ({dout_valid, dout} !== {1'b1, 8'd6})
      $display("FAIL lat_send got valid=%b dout=%0d exp 1 6", dout_valid, dout); else n_pass++;
    waited = 0;
    while (done !== 1'b1 && waited < 50) begin @(negedge clk); waited++; end
    n_checks++; if ({done, busy, checksum} !== {1'b1, 1'b0, 8'd6})
      $display("FAIL lat_done got done=%b busy=%b sum=%0d exp 1 0 6", done, busy, checksum); else n_pass++;
  endtask

  task automatic test_basic();
    int bad;
    run_dump(8'd128, 8'd131, 0, 0, 1'b0, 0);
    n_checks++; if (timed_out) $display("FAIL basic_timeout got=timeout exp=done"); else n_pass++;
    bad = 0;
    for (int i = 0; i < 4; i++) if (i >= dw.size() || dw[i] !== exp_words[i]) bad++;
    n_checks++; if (bad !== 0 || dw.size() !== 4)
      $display("FAIL basic_words got_n=%0d bad=%0d exp_n=4 (6,1,2,0)", dw.size(), bad); else n_pass++;
    bad = 0;
    for (int i = 0; i < 4; i++) if (i >= da.size() || da[i] !== 8'(128 + i)) bad++;
    n_checks++; if (bad !== 0 || dump_rd !== 4)
      $display("FAIL basic_reads got_rd=%0d bad_addr=%0d exp_rd=4", dump_rd, bad); else n_pass++;
    n_checks++; if ({done, busy, checksum} !== {1'b1, 1'b0, 8'd9})
      $display("FAIL basic_final got done=%b busy=%b sum=%0d exp 1 0 9", done, busy, checksum); else n_pass++;
  endtask

  task automatic test_stall();
    run_dump(8'd128, 8'd131, 1, 5, 1'b0, 0);
    n_checks++; if (stall_seen !== 5 || stall_bad !== 0)
      $display("FAIL stall_hold got cycles=%0d bad=%0d exp 5 0", stall_seen, stall_bad); else n_pass++;
    n_checks++; if (timed_out || dw.size() !== 4 || dump_rd !== 4 || checksum !== 8'd9)
      $display("FAIL stall_final got n=%0d rd=%0d sum=%0d exp 4 4 9", dw.size(), dump_rd, checksum); else n_pass++;
  endtask

  task automatic test_single();
    run_dump(8'd139, 8'd139, 0, 0, 1'b0, 0);
    n_checks++; if (timed_out || dw.size() !== 1 || dw[0] !== 8'hF0 || dump_rd !== 1)
      $display("FAIL single_word got n=%0d w0=%h rd=%0d exp 1 f0 1", dw.size(), dw[0], dump_rd); else n_pass++;
    n_checks++; if ({done, checksum} !== {1'b1, 8'hF0})
      $display("FAIL single_sum got done=%b sum=%h exp 1 f0", done, checksum); else n_pass++;
  endtask

  task automatic test_wrap();
    int bad;
    run_dump(8'd254, 8'd1, 0, 0, 1'b0, 0);
    bad = 0;
    for (int i = 0; i < 4; i++) if (i >= dw.size() || dw[i] !== exp_words[i] || da[i] !== exp_addrs[i]) bad++;
    n_checks++; if (timed_out || bad !== 0 || dw.size() !== 4)
      $display("FAIL wrap_words got n=%0d bad=%0d exp n=4 (200,100,0,1)", dw.size(), bad); else n_pass++;
    n_checks++; if (checksum !== 8'd45)
      $display("FAIL wrap_sum got=%0d exp=45", checksum); else n_pass++;
  endtask

  task automatic test_mid_start();
    int bad;
    run_dump(8'd128, 8'd131, 0, 0, 1'b0, 1);
    bad = 0;
    for (int i = 0; i < 4; i++) if (i >= dw.size() || dw[i] !== exp_words[i] || da[i] !== exp_addrs[i]) bad++;
    n_checks++; if (timed_out || bad !== 0 || dw.size() !== 4 || dump_rd !== 4 || checksum !== 8'd9)
      $display("FAIL midstart_seq got n=%0d bad=%0d rd=%0d sum=%0d exp 4 0 4 9", dw.size(), bad, dump_rd, checksum);
    else n_pass++;
  endtask

  // Start coinciding with the final handshake must not launch a new dump
  task automatic test_final_start();
    int rd0;
    run_dump(8'd128, 8'd131, 0, 0, 1'b0, 2);
    rd0 = rd_cnt;
    repeat (4) @(negedge clk);
    n_checks++; if (timed_out || {done, busy, checksum} !== {1'b1, 1'b0, 8'd9} || rd_cnt !== rd0 || dw.size() !== 4)
      $display("FAIL finalstart_ignored got done=%b busy=%b sum=%0d extra_rd=%0d n=%0d exp 1 0 9 0 4",
               done, busy, checksum, rd_cnt - rd0, dw.size());
    else n_pass++;
  endtask

  task automatic test_abort();
    int  bw, rd0, bad;
    bit  found;
    bw = got_words.size();
    @(posedge clk); #1;
    first_addr = 8'd128; last_addr = 8'd131; start = 1'b1; dout_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (got_words.size() - bw == 1 && dout_valid === 1'b1) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    n_checks++; if (!found) $display("FAIL abort_reach_send got=timeout exp=word2 valid"); else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++; if ({mem_addr, mem_rd, dout, dout_valid, busy, done, checksum} !== 35'd0)
      $display("FAIL abort_outputs got addr=%0d rd=%b dout=%0d v=%b busy=%b done=%b sum=%0d exp all 0",
               mem_addr, mem_rd, dout, dout_valid, busy, done, checksum);
    else n_pass++;
    rd0 = rd_cnt;
    repeat (3) @(negedge clk);
    n_checks++; if (mem_rd !== 1'b0 || dout_valid !== 1'b0 || rd_cnt !== rd0)
      $display("FAIL abort_quiet got rd=%b v=%b reads=%0d exp 0 0 0", mem_rd, dout_valid, rd_cnt - rd0); else n_pass++;
    rst = 1'b1;
    run_dump(8'd128, 8'd131, 0, 0, 1'b0, 0);
    bad = 0;
    for (int i = 0; i < 4; i++) if (i >= dw.size() || dw[i] !== exp_words[i]) bad++;
    n_checks++; if (timed_out || bad !== 0 || dw.size() !== 4 || checksum !== 8'd9 || done !== 1'b1)
      $display("FAIL abort_fresh got n=%0d bad=%0d sum=%0d done=%b exp 4 0 9 1", dw.size(), bad, checksum, done);
    else n_pass++;
  endtask

  task automatic test_random();
    int         bad, len;
    logic [7:0] f, l;
    for (int it = 0; it < 7; it++) begin
      for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
      f = 8'($urandom);
      len = (it == 6) ? 256 : $urandom_range(1, 40);
      l = 8'(int'(f) + len - 1);
      run_dump(f, l, 0, 0, 1'b1, 0);
      bad = 0;
      for (int i = 0; i < exp_words.size(); i++)
        if (i >= dw.size() || dw[i] !== exp_words[i] || da[i] !== exp_addrs[i]) bad++;
      n_checks++; if (timed_out || bad !== 0 || dw.size() !== exp_words.size() || dump_rd !== exp_words.size())
        $display("FAIL rand_seq it=%0d f=%0d l=%0d got n=%0d rd=%0d bad=%0d exp n=%0d",
                 it, f, l, dw.size(), dump_rd, bad, exp_words.size());
      else n_pass++;
      n_checks++; if (checksum !== exp_sum || done !== 1'b1)
        $display("FAIL rand_sum it=%0d got sum=%0d done=%b exp %0d 1", it, checksum, done, exp_sum); else n_pass++;
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    mem[128] = 8'd6; mem[129] = 8'd1; mem[130] = 8'd2; mem[131] = 8'd0;
    mem[139] = 8'hF0;
    mem[254] = 8'd200; mem[255] = 8'd100; mem[0] = 8'd0; mem[1] = 8'd1;
    test_reset();
    test_latency();
    test_basic();
    test_stall();
    test_single();
    test_wrap();
    test_mid_start();
    test_final_start();
    test_abort();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_dump_unit.md
Name: sram_dump_unit

Overview:
- Reader-side counterpart to program/data loading of the RISC_SPM SRAM.
- After the processor halts, the block walks an address range of the SRAM through its read port and streams each word out on a valid/ready byte interface, accumulating a modulo-2^word_size checksum.
- Sits beside RISC_SPM and shares the SRAM read port; it is used for post-run memory readback in hardware and on the bench.

Parameters:
- word_size, 8, data width of SRAM words and output stream.
- addr_size, 8, SRAM address width (256 locations).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a dump; sampled only in IDLE or DONE.
- first_addr  input  addr_size  first address to read; sampled on accepted start.
- last_addr  input  addr_size  final address to read, inclusive; sampled on accepted start.
- mem_addr  output  addr_size  SRAM read address.
- mem_rd  output  1  SRAM read strobe.
- mem_data  input  word_size  SRAM read data, valid exactly one cycle after mem_rd.
- dout  output  word_size  streamed word.
- dout_valid  output  1  dout holds a word.
- dout_ready  input  1  sink accepts the word when high together with dout_valid.
- busy  output  1  dump in progress.
- done  output  1  level; dump finished; cleared by the next accepted start.
- checksum  output  word_size  sum of all accepted words, mod 2^word_size.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; mem_addr=0, mem_rd=0, dout=0, dout_valid=0, busy=0, done=0, checksum=0; latched range cleared.
- A reset mid-dump aborts immediately with no further reads or output.
- FSM states: IDLE, READ, CAPT, SEND, DONE.
- IDLE/DONE, start=1:
  - latch first_addr into the address counter and last_addr into the end register;
  - clear checksum and done; set busy; go to READ.
- READ: drive mem_addr=counter and mem_rd=1 for exactly one cycle; go to CAPT.
- CAPT: mem_rd=0; register mem_data into dout; go to SEND.
- SEND: dout_valid=1.
  - dout and dout_valid stay stable until a handshake (dout_valid & dout_ready).
  - On handshake: checksum <= checksum + dout (wraps); dout_valid drops next cycle.
  - After handshake, if counter == end register: go to DONE.
  - Otherwise: counter <= counter + 1 (wraps 2^addr_size-1 -> 0) and go to READ.
- DONE: busy=0, done=1; dout holds the last word; checksum holds its final value.
- Throughput: with dout_ready held high, one word per 3 cycles. The first dout_valid rises 3 cycles after the start cycle.
- Range rules:
  - first_addr == last_addr: exactly one word.
  - last_addr < first_addr: the counter wraps through 0, giving (last - first + 2^addr_size) mod 2^addr_size + 1 words.
  - A full 256-word dump uses first = last + 1.
- start while busy: ignored, with no effect on the counter, checksum or output.
- start in the same cycle as the final handshake: ignored; a new start is accepted from DONE.
- dout_ready with dout_valid low: ignored.
- mem_rd is never asserted outside READ.

Test Plan:
- Preload memory[128..131] = 6,1,2,0; dump 128..131 with ready tied high. Required: dout sequence 6,1,2,0; mem_addr 128,129,130,131, each with a single mem_rd pulse; done=1 and checksum=9; busy low in DONE.
- Same dump with dout_ready low for 5 cycles on the second word. Required: dout stays 1 with valid high throughout; no mem_rd during the stall; final checksum=9.
- first=last=139 with memory[139]=8'hF0. Required: one word 8'hF0; checksum=8'hF0; done after a single handshake.
- Wrap: memory[254]=200, [255]=100, [0]=0, [1]=1; dump 254..1. Required: 4 words 200,100,0,1 in that order; checksum=45 (301 mod 256).
- Pulse start mid-dump of 128..131. Required: ignored, with an unchanged sequence and checksum. Then assert rst low during SEND of word 2. Required: all outputs 0 immediately and state IDLE; a subsequent start performs a fresh, complete dump.
